// File: rtl/key_pkg.sv
// Shared constants and helpers for the multi-channel key press counter.
package key_pkg;

    localparam int unsigned KEY_NUM_CH         = 4;
    localparam int unsigned KEY_CNT_W          = 16;
    localparam int unsigned KEY_DEBOUNCE_SIM   = 4;
    localparam int unsigned KEY_DEBOUNCE_BOARD = 500000;

    typedef enum logic {
        CntWrap = 1'b0,
        CntSat  = 1'b1
    } cnt_mode_e;

    // Readout select width; a single channel still gets a 1-bit select.
    function automatic int unsigned key_sel_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/key_press_counter_if.sv
// Key/control inputs and counter outputs of the key press counter.
interface key_press_counter_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned SEL_W  = 2
) ();

    logic [NUM_CH-1:0] key_n;
    logic [NUM_CH-1:0] clear;
    logic              sat_mode;
    logic [SEL_W-1:0]  sel;
    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] overflow;
    logic [CNT_W-1:0]  count;

    modport master (
        output key_n, clear, sat_mode, sel,
        input  pulse, overflow, count
    );

    modport slave (
        input  key_n, clear, sat_mode, sel,
        output pulse, overflow, count
    );

endinterface

// File: rtl/key_debouncer.sv
// One key channel: 2-flop synchroniser, debounce filter and registered press strobe.
module key_debouncer #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic pulse,
    output logic level
);

    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic [1:0]    sync_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          pulse_q, pulse_d;
    logic          press;

    assign press = ~sync_q[1];

    always_comb begin
        stable_d = stable_q;
        dcnt_d   = '0;
        pulse_d  = 1'b0;
        if (press != stable_q) begin
            if (dcnt_q == LAST) begin
                stable_d = press;
                pulse_d  = press;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    // Sync flops reset to the released level so a held key is seen as a fresh press.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b0;
            dcnt_q   <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], key_n};
            stable_q <= stable_d;
            dcnt_q   <= dcnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign pulse = pulse_q;
    assign level = stable_q;

endmodule

// File: rtl/key_press_counter.sv
// Multi-channel debounced key press counter with sticky overflow and registered readout.
module key_press_counter
    import key_pkg::*;
#(
    parameter int unsigned NUM_CH   = KEY_NUM_CH,
    parameter int unsigned CNT_W    = KEY_CNT_W,
    parameter int unsigned DEBOUNCE = KEY_DEBOUNCE_SIM,
    parameter int unsigned SEL_W    = key_sel_w(NUM_CH)
) (
    input logic CLOCK_50,
    input logic reset,
    key_press_counter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] level;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [NUM_CH-1:0] ovf_q;
    logic [CNT_W-1:0]  count_q, count_d;
    cnt_mode_e         mode;

    assign mode = cnt_mode_e'(bus.sat_mode);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        key_debouncer #(
            .DEBOUNCE(DEBOUNCE)
        ) u_deb (
            .CLOCK_50(CLOCK_50),
            .reset   (reset),
            .key_n   (bus.key_n[g]),
            .pulse   (pulse[g]),
            .level   (level[g])
        );
    end

    // Clear outranks a coincident press; a press at max always flags overflow.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.clear[i]) begin
                    cnt_q[i] <= '0;
                    ovf_q[i] <= 1'b0;
                end else if (pulse[i]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        ovf_q[i] <= 1'b1;
                        if (mode == CntWrap) begin
                            cnt_q[i] <= '0;
                        end
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Out-of-range selects read as zero.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(bus.sel) == i) begin
                count_d = cnt_q[i];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.pulse    = pulse;
    assign bus.overflow = ovf_q;
    assign bus.count    = count_q;

    logic unused_level;
    assign unused_level = ^level;

endmodule

// File: doc/key_press_counter.md
# key_press_counter

Parametrised multi-channel push-button press counter: the next generation of the board's per-key press counters. Each raw active-low key passes through a synchroniser and a debouncer, then an edge detector, into its own counter. Counters wrap or saturate, can be cleared per channel, and flag overflow. One selected channel's count is presented on a registered readout for the seven-segment display path.

## Interface
- NUM_CH, 4, number of key channels (1..16)
- CNT_W, 16, counter width per channel (2..32)
- DEBOUNCE, 4, consecutive stable samples required to accept a level change (1..2^20; board build uses 500000)
- SEL_W, $clog2(NUM_CH) (min 1), readout select width
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- key_n  in  NUM_CH  raw asynchronous keys, active-low (0 = pressed)
- clear  in  NUM_CH  synchronous per-channel clear of count and overflow
- sat_mode  in  1  1 = saturate at max, 0 = wrap to 0; applies to all channels, sampled every cycle
- sel  in  SEL_W  readout channel select
- pulse  out  NUM_CH  registered one-cycle press strobe per channel
- overflow  out  NUM_CH  sticky per-channel overflow flag
- count  out  CNT_W  registered count of channel sel

## Operation
- Sync: 2-flop synchroniser per key_n bit, reset to 1 (released); inverted internally to press = 1.
- Debounce per channel: stable level register plus counter of width $clog2(DEBOUNCE+1).
  - synced level == stable: counter cleared.
  - synced level != stable: counter increments; when counter reaches DEBOUNCE-1 (i.e. DEBOUNCE consecutive disagreeing samples), stable takes the new level and counter clears.
  - Any agreeing sample mid-count clears counter: bounces shorter than DEBOUNCE are rejected.
- Edge: pulse[i] = 1 for exactly one cycle, registered in the same edge that stable goes 0->1. Release (1->0) never pulses.
- Counter per channel, evaluated each edge, priority high to low:
  - clear[i]: cnt <= 0, overflow[i] <= 0 (a coincident pulse is discarded).
  - pulse[i] and cnt < max: cnt <= cnt+1.
  - pulse[i] and cnt == max (2^CNT_W-1): wrap mode cnt <= 0; saturate mode cnt unchanged; both set overflow[i] <= 1.
- overflow is sticky; cleared only by clear[i] or reset.
- Readout: count <= cnt[sel] each edge; sel >= NUM_CH drives count <= 0.
- Channels fully independent; simultaneous presses on all channels all counted.
- Reset values: all sync flops 1 (released), stable 0, debounce counters 0, pulse 0, all counts 0, overflow 0, count 0.
- Reset mid-debounce abandons the pending change. A key held through reset deassertion is seen as a fresh press and counted once after DEBOUNCE+2 edges.

## Timing
- key_n falling, set up before edge E1: synced press visible after E2; stable and pulse rise at edge E(DEBOUNCE+2); pulse falls at the next edge.
- cnt increments at the edge after pulse is high; count output reflects it one edge later (pulse-to-count latency 2 edges).
- sel change to count: 1 edge.
- clear: cnt and overflow zero after the edge sampling clear; count shows 0 one edge later.
- Minimum press or release duration accepted: DEBOUNCE cycles after synchronisation; maximum press rate: one per 2*DEBOUNCE cycles per channel.

## Structure
- Shared package key_pkg: default constants KEY_NUM_CH=4, KEY_CNT_W=16, KEY_DEBOUNCE_SIM=4, KEY_DEBOUNCE_BOARD=500000.
- Sub-module key_debouncer, one instance per channel (generate loop): synchroniser, debounce counter, stable register, registered press pulse. Ports CLOCK_50, reset, key_n, pulse, level.
- Counters, overflow logic and readout mux live in the top.
- Seven-segment decoding stays external; count feeds the existing display decoder.

## Test plan
- DEBOUNCE=4, hold key_n[0]=0 for 20 cycles -> pulse[0] high exactly one cycle at edge 6; count (sel=0) goes 0->1 two edges later; other pulses remain 0.
- Bounce: key_n[1] low 3 cycles, high 1, low 3, then high -> no pulse[1]; count for channel 1 stays 0.
- CNT_W=2, sat_mode=0, 4 clean presses on ch2 -> counts 1,2,3,0; overflow[2] sets on 4th press and stays 1. Repeat with sat_mode=1 -> 1,2,3,3, overflow set on 4th press.
- clear[3] asserted in the same cycle as pulse[3] with cnt=5 -> cnt becomes 0, not 1; overflow[3]=0.
- All four keys pressed simultaneously, 3 presses each -> every channel reads 3 via sel=0..3; sel=7 (NUM_CH=4, SEL_W=3) -> count=0.
- reset asserted mid-debounce with key held, released while still held -> all outputs 0 during reset; one pulse at edge DEBOUNCE+2 after release; count reads 1.
